// File: rtl/branch_resolver_pkg.sv
// Shared CPU definitions: condition codes, ALU flag bit positions and resolver FSM states.
package branch_resolver_pkg;

  localparam int FLAG_O = 3;
  localparam int FLAG_S = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [3:0] {
    COND_AL = 4'd0,
    COND_EQ = 4'd1,
    COND_NE = 4'd2,
    COND_MI = 4'd3,
    COND_PL = 4'd4,
    COND_CS = 4'd5,
    COND_CC = 4'd6,
    COND_VS = 4'd7,
    COND_VC = 4'd8,
    COND_GT = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_LE = 4'd12,
    COND_HI = 4'd13,
    COND_LS = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

endpackage

// File: rtl/branch_resolver_cond_eval.sv
// Combinational branch condition evaluation against the {O,S,Z,C} flag register.
module branch_cond_eval
  import branch_resolver_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic o, s, z, c;

  assign o = flags[FLAG_O];
  assign s = flags[FLAG_S];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];

  // C=1 means "no borrow", so unsigned above is C & !Z
  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_MI: taken = s;
      COND_PL: taken = !s;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_VS: taken = o;
      COND_VC: taken = !o;
      COND_GT: taken = !z && (s == o);
      COND_GE: taken = (s == o);
      COND_LT: taken = (s != o);
      COND_LE: taken = z || (s != o);
      COND_HI: taken = c && !z;
      COND_LS: taken = !c || z;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: checks prediction, issues resolve pulse or redirect + flush sequence.
// Optional saturating statistics counters enabled by BRANCH_STATS_EN.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [3:0]      br_cond,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_target,
  input  logic            pred_taken,
  input  logic [3:0]      flags,
  input  logic            kill,
  output logic            resolve_valid,
  output logic            resolve_taken,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [15:0]     stat_branches,
  output logic [15:0]     stat_mispredicts
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_e          state_q;
  logic [2:0]      cnt_q;
  logic            br_ready_q;
  logic            resolve_valid_q;
  logic            resolve_taken_q;
  logic            redirect_valid_q;
  logic            flush_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic            taken;
  logic            accept;
  logic            mispredict;
  logic [XLEN-1:0] next_pc;

  branch_cond_eval u_cond_eval (
    .cond  (br_cond),
    .flags (flags),
    .taken (taken)
  );

  assign accept     = br_valid && (state_q == IDLE) && !kill;
  assign mispredict = accept && (taken != pred_taken);
  assign next_pc    = taken ? br_target : br_pc + XLEN'(1);

  // kill overrides every state; resolve_valid is a single-cycle pulse by default-low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= 3'd0;
      br_ready_q       <= 1'b1;
      resolve_valid_q  <= 1'b0;
      resolve_taken_q  <= 1'b0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      resolve_valid_q <= 1'b0;
      if (kill) begin
        state_q          <= IDLE;
        cnt_q            <= 3'd0;
        br_ready_q       <= 1'b1;
        redirect_valid_q <= 1'b0;
        flush_q          <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              resolve_taken_q <= taken;
              if (mispredict) begin
                redirect_pc_q    <= next_pc;
                redirect_valid_q <= 1'b1;
                flush_q          <= 1'b1;
                br_ready_q       <= 1'b0;
                state_q          <= REDIRECT;
              end else begin
                resolve_valid_q <= 1'b1;
              end
            end
          end
          REDIRECT: begin
            if (redirect_ready) begin
              redirect_valid_q <= 1'b0;
              if (FLUSH_CYCLES > 0) begin
                state_q <= FLUSH;
                cnt_q   <= FLUSH_INIT;
              end else begin
                state_q    <= IDLE;
                flush_q    <= 1'b0;
                br_ready_q <= 1'b1;
              end
            end
          end
          FLUSH: begin
            if (cnt_q <= 3'd1) begin
              state_q    <= IDLE;
              cnt_q      <= 3'd0;
              flush_q    <= 1'b0;
              br_ready_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 3'd1;
            end
          end
          default: begin
            state_q    <= IDLE;
            br_ready_q <= 1'b1;
            flush_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign br_ready       = br_ready_q;
  assign resolve_valid  = resolve_valid_q;
  assign resolve_taken  = resolve_taken_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] stat_br_q;
  logic [15:0] stat_mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q  <= 16'd0;
      stat_mis_q <= 16'd0;
    end else begin
      if (accept && (stat_br_q != 16'hFFFF)) begin
        stat_br_q <= stat_br_q + 16'd1;
      end
      if (mispredict && (stat_mis_q != 16'hFFFF)) begin
        stat_mis_q <= stat_mis_q + 16'd1;
      end
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;
`else
  assign stat_branches    = 16'd0;
  assign stat_mispredicts = 16'd0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: FLUSH_CYCLES=2 and FLUSH_CYCLES=0 instances.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        br_valid = 1'b0;
  logic        br_valid0 = 1'b0;
  logic [3:0]  br_cond = 4'd0;
  logic [15:0] br_pc = 16'd0;
  logic [15:0] br_target = 16'd0;
  logic        pred_taken = 1'b0;
  logic [3:0]  flags = 4'd0;
  logic        kill = 1'b0;
  logic        redirect_ready = 1'b0;
  logic        redirect_ready0 = 1'b0;

  logic        br_ready, resolve_valid, resolve_taken, redirect_valid, flush;
  logic [15:0] redirect_pc, stat_branches, stat_mispredicts;
  logic        br_ready0, resolve_valid0, resolve_taken0, redirect_valid0, flush0;
  logic [15:0] redirect_pc0, stat_branches0, stat_mispredicts0;

  int total = 0;
  int bad = 0;
  int excl_err = 0;
  logic [15:0] exp_br = 16'd0;
  logic [15:0] exp_mis = 16'd0;

  always #5 clk = ~clk;

  branch_resolver #(.FLUSH_CYCLES(2), .XLEN(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
    .br_cond(br_cond), .br_pc(br_pc), .br_target(br_target), .pred_taken(pred_taken),
    .flags(flags), .kill(kill), .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
    .flush(flush), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  branch_resolver #(.FLUSH_CYCLES(0), .XLEN(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid0), .br_ready(br_ready0),
    .br_cond(br_cond), .br_pc(br_pc), .br_target(br_target), .pred_taken(pred_taken),
    .flags(flags), .kill(kill), .resolve_valid(resolve_valid0), .resolve_taken(resolve_taken0),
    .redirect_valid(redirect_valid0), .redirect_ready(redirect_ready0), .redirect_pc(redirect_pc0),
    .flush(flush0), .stat_branches(stat_branches0), .stat_mispredicts(stat_mispredicts0)
  );

  always @(negedge clk) begin
    if ((resolve_valid && redirect_valid) || (resolve_valid0 && redirect_valid0)) excl_err++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic ref_taken(input logic [3:0] cd, input logic [3:0] f);
    logic o, s, z, c;
    o = f[3]; s = f[2]; z = f[1]; c = f[0];
    case (cd)
      4'd0:  return 1'b1;
      4'd1:  return z;
      4'd2:  return !z;
      4'd3:  return s;
      4'd4:  return !s;
      4'd5:  return c;
      4'd6:  return !c;
      4'd7:  return o;
      4'd8:  return !o;
      4'd9:  return !z && (s == o);
      4'd10: return s == o;
      4'd11: return s != o;
      4'd12: return z || (s != o);
      4'd13: return c && !z;
      4'd14: return !c || z;
      default: return 1'b0;
    endcase
  endfunction

  // Offer one branch to u_dut for a single cycle; caller is 1 time unit after a posedge.
  task automatic offer(input logic [3:0] cd, input logic [3:0] fl, input logic [15:0] pc,
                       input logic [15:0] tg, input logic pr);
    br_cond = cd; flags = fl; br_pc = pc; br_target = tg; pred_taken = pr;
    br_valid = 1'b1;
    @(posedge clk); #1;
    br_valid = 1'b0;
`ifdef BRANCH_STATS_EN
    if (exp_br != 16'hFFFF) exp_br++;
    if (ref_taken(cd, fl) != pr && exp_mis != 16'hFFFF) exp_mis++;
`endif
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_br_ready", br_ready, 1);
    chk("rst_resolve_valid", resolve_valid, 0);
    chk("rst_resolve_taken", resolve_taken, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_stat_br", stat_branches, 0);
    chk("rst_stat_mis", stat_mispredicts, 0);
    #9 rst_n = 1'b1;
    step();

    // Correctly predicted taken EQ branch
    offer(4'd1, 4'b0010, 16'h0010, 16'h0040, 1'b1);
    chk("hit_resolve_valid", resolve_valid, 1);
    chk("hit_resolve_taken", resolve_taken, 1);
    chk("hit_redirect_valid", redirect_valid, 0);
    chk("hit_flush", flush, 0);
    step();
    chk("hit_pulse_ends", resolve_valid, 0);

    // Mispredict not-taken at PC 0xFFFF wraps to 0x0000
    offer(4'd1, 4'b0000, 16'hFFFF, 16'h1234, 1'b1);
    chk("mp_redirect_valid", redirect_valid, 1);
    chk("mp_redirect_pc", redirect_pc, 16'h0000);
    chk("mp_resolve_taken", resolve_taken, 0);
    chk("mp_resolve_valid", resolve_valid, 0);
    chk("mp_br_ready", br_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mp_hold_valid", redirect_valid, 1);
      chk("mp_hold_pc", redirect_pc, 16'h0000);
      chk("mp_hold_flush", flush, 1);
    end
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    chk("hs_redirect_drop", redirect_valid, 0);
    chk("hs_flush1", flush, 1);
    step();
    chk("hs_flush2", flush, 1);
    chk("hs_ready_low", br_ready, 0);
    step();
    chk("hs_flush_end", flush, 0);
    chk("hs_ready_back", br_ready, 1);

    // Condition sweep, prediction chosen to match the reference model
    for (int cd = 0; cd < 16; cd++) begin
      for (int f = 0; f < 16; f++) begin
        logic exp_t;
        exp_t = ref_taken(4'(cd), 4'(f));
        offer(4'(cd), 4'(f), 16'h0100, 16'h0200, exp_t);
        chk($sformatf("cond%0d_f%0h_valid", cd, f), resolve_valid, 1);
        chk($sformatf("cond%0d_f%0h_taken", cd, f), resolve_taken, exp_t);
        if (redirect_valid) begin
          kill = 1'b1; step(); kill = 1'b0;
        end
      end
    end
    offer(4'd11, 4'b1000, 16'h0100, 16'h0200, 1'b0);
    chk("lt_o_only_taken", resolve_taken, 1);
    chk("lt_o_only_redirect_pc", redirect_pc, 16'h0200);

    // Kill while in REDIRECT
    chk("kill_pre_redirect", redirect_valid, 1);
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_redirect_drop", redirect_valid, 0);
    chk("kill_flush_drop", flush, 0);
    chk("kill_br_ready", br_ready, 1);

    // Kill in the same cycle as a branch offer
    br_cond = 4'd0; pred_taken = 1'b1; kill = 1'b1; br_valid = 1'b1;
    step();
    kill = 1'b0; br_valid = 1'b0;
    chk("killacc_no_resolve", resolve_valid, 0);
    chk("killacc_no_redirect", redirect_valid, 0);
    chk("killacc_stat_br", stat_branches, exp_br);
    chk("killacc_stat_mis", stat_mispredicts, exp_mis);

    // FLUSH_CYCLES=0: handshake returns straight to IDLE
    br_cond = 4'd15; pred_taken = 1'b1; br_pc = 16'h0030; br_valid0 = 1'b1;
    step();
    br_valid0 = 1'b0;
    chk("f0_redirect_valid", redirect_valid0, 1);
    chk("f0_redirect_pc", redirect_pc0, 16'h0031);
    chk("f0_br_ready_low", br_ready0, 0);
    redirect_ready0 = 1'b1;
    step();
    redirect_ready0 = 1'b0;
    chk("f0_br_ready", br_ready0, 1);
    chk("f0_redirect_drop", redirect_valid0, 0);
    chk("f0_flush", flush0, 0);

    // Reset asserted mid-FLUSH
    offer(4'd0, 4'b0000, 16'h0000, 16'h0800, 1'b0);
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    chk("rf_in_flush", flush, 1);
    rst_n = 1'b0;
    #1;
    exp_br = 16'd0; exp_mis = 16'd0;
    chk("rf_flush", flush, 0);
    chk("rf_redirect_valid", redirect_valid, 0);
    chk("rf_redirect_pc", redirect_pc, 0);
    chk("rf_resolve_taken", resolve_taken, 0);
    chk("rf_stat_br", stat_branches, 0);
    chk("rf_stat_mis", stat_mispredicts, 0);
    #2 rst_n = 1'b1;
    step();
    offer(4'd0, 4'b0000, 16'h0004, 16'h0050, 1'b1);
    chk("rf_accept_after_reset", resolve_valid, 1);
    chk("rf_stat_br_after", stat_branches, exp_br);

`ifdef BRANCH_STATS_EN
    rst_n = 1'b0; #1 rst_n = 1'b1;
    step();
    br_cond = 4'd15; pred_taken = 1'b1; redirect_ready0 = 1'b1; br_valid0 = 1'b1;
    repeat (2 * 65537) @(posedge clk);
    #1;
    br_valid0 = 1'b0; redirect_ready0 = 1'b0;
    chk("sat_stat_br", stat_branches0, 16'hFFFF);
    chk("sat_stat_mis", stat_mispredicts0, 16'hFFFF);
`endif

    chk("resolve_redirect_exclusive", excl_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of flush cycles after a redirect handshake (legal range 0..7).
REQ-002 SHALL have parameter XLEN, default 16, meaning the PC/address width.
REQ-003 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- br_valid  in  1  a branch is offered from execute.
- br_ready  out  1  resolver can accept a branch.
- br_cond  in  4  condition code.
- br_pc  in  XLEN  PC of the branch.
- br_target  in  XLEN  computed target.
- pred_taken  in  1  fetch-stage prediction.
- flags  in  4  ALU flag register {O,S,Z,C}.
- kill  in  1  an older instruction faulted; abort.
- resolve_valid  out  1  one-cycle pulse: branch resolved correctly predicted.
- resolve_taken  out  1  actual direction, valid with resolve_valid or redirect_valid.
- redirect_valid  out  1  fetch must redirect.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_pc  out  XLEN  corrected PC.
- flush  out  1  invalidate younger pipeline stages.
- stat_branches  out  16  resolved-branch count.
- stat_mispredicts  out  16  mispredict count.

Function
REQ-004 SHALL decode br_cond as follows: 0 always; 1 Z; 2 !Z; 3 S; 4 !S; 5 C; 6 !C; 7 O; 8 !O; 9 signed gt (!Z & S==O); 10 signed ge (S==O); 11 signed lt (S!=O); 12 signed le (Z | S!=O); 13 unsigned above (C & !Z, where C=1 means no borrow); 14 unsigned below-or-equal (!C | Z); 15 never.
REQ-005 SHALL implement FSM states IDLE, REDIRECT and FLUSH, with br_ready=1 only in IDLE.
REQ-006 SHALL accept a branch when br_valid & br_ready & !kill, sampling flags and all br_* inputs in the accept cycle.
REQ-007 SHALL compute actual next PC as br_target if taken, else br_pc+1 modulo 2^XLEN, so 0xFFFF+1 wraps to 0x0000.
REQ-008 SHALL, on accept with taken==pred_taken, stay in IDLE and pulse resolve_valid in the next cycle with resolve_taken set, and SHALL leave redirect_valid and flush low.
REQ-009 SHALL, on accept with taken!=pred_taken, register redirect_pc and resolve_taken and enter REDIRECT the next cycle.
REQ-010 SHALL hold redirect_valid=1 and flush=1 in REDIRECT, with redirect_pc stable until redirect_ready is sampled high.
REQ-011 SHALL, on the redirect handshake, go to FLUSH when FLUSH_CYCLES>0, else to IDLE.
REQ-012 SHALL hold flush=1 for exactly FLUSH_CYCLES cycles in FLUSH, using a down-counter, then return to IDLE.
REQ-013 SHALL treat kill as highest priority: in any state, the next state is IDLE, no branch is accepted, redirect_valid drops the next cycle, and no resolve_valid pulse is issued for a kill arriving in the accept cycle.
REQ-014 SHALL register every output; resolve_valid SHALL never be high in the same cycle as redirect_valid.

Reset
REQ-015 SHALL, on rst_n low, asynchronously enter IDLE with the flush counter at 0 and drive resolve_valid, resolve_taken, redirect_valid and flush to 0, redirect_pc to 0, and both stat counters to 0.
REQ-016 SHALL, on reset mid-REDIRECT or mid-FLUSH, abandon the redirect and accept a branch in the first cycle after rst_n deasserts.

Configuration
REQ-017 SHALL, with BRANCH_STATS_EN defined, increment stat_branches on each accepted, non-killed branch and stat_mispredicts on each mispredict; both counters SHALL saturate at 0xFFFF.
REQ-018 SHALL, without BRANCH_STATS_EN, drive both stat outputs to constant 0 and contain no counter flops.

Structure
REQ-019 SHALL take condition-code constants (COND_*), FSM state encodings and the flag bit indices (O=3, S=2, Z=1, C=0) from the shared CPU package, so the ALU and this block agree.
REQ-020 SHALL place condition evaluation in the combinational sub-module branch_cond_eval (inputs cond and flags, output taken).

Verification
REQ-021 SHALL verify that flags=0010, cond=1, pred_taken=1, target=0x0040 produces a resolve_valid pulse with taken=1, and no redirect or flush.
REQ-022 SHALL verify that flags=0000, cond=1, pred_taken=1, pc=0xFFFF produces redirect_pc=0x0000; with redirect_ready held low 3 cycles, redirect stays stable, then flush lasts exactly 2 cycles after the handshake.
REQ-023 SHALL verify that, for cond 9..14 over all 16 flag values, the result matches a reference model, including flags=1000 and cond=11 giving taken=1.
REQ-024 SHALL verify that kill asserted in REDIRECT returns the FSM to IDLE next cycle, and that kill in the same cycle as br_valid leaves stat_branches unchanged.
REQ-025 SHALL verify that with FLUSH_CYCLES=0, a mispredict followed by the handshake returns the FSM to IDLE with br_ready=1 in the next cycle.
REQ-026 SHALL verify that, with BRANCH_STATS_EN, 65537 mispredicts leave both counters at 0xFFFF, and that rst_n pulsed mid-FLUSH clears all outputs immediately.
